// File: rtl/noc_flit_pkg.sv
// rtl/noc_flit_pkg.sv - shared flit encodings, reserved-byte rule and transmit state enum
package noc_flit_pkg;

  localparam logic [5:0] HEAD_TAG   = 6'b101111;
  localparam logic [7:0] FLIT_IDLE  = 8'h00;
  localparam logic [7:0] FLIT_TAIL  = 8'hFF;
  localparam logic [7:0] FLIT_SUBST = 8'h01;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_FREE = 3'd1,
    HEAD      = 3'd2,
    BODY      = 3'd3,
    TAIL      = 3'd4,
    GAP       = 3'd5
  } tx_state_e;

  // Bytes that would alias idle, tail or any head flit on the line
  function automatic logic is_reserved(input logic [7:0] b);
    return (b == FLIT_IDLE) || (b == FLIT_TAIL) || (b[7:2] == HEAD_TAG);
  endfunction

endpackage

// File: rtl/ni_byte_fifo.sv
// rtl/ni_byte_fifo.sv - synchronous byte FIFO with show-ahead read data
module ni_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array: written on accepted pushes only, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth; push+pop leaves count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ni_flit_packetizer.sv
// rtl/ni_flit_packetizer.sv - NI transmit packetizer (optional NI_STATS_EN packet/flit counters)
module ni_flit_packetizer
  import noc_flit_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 4,
  parameter int MIN_GAP    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  current_node,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  input  logic                        tx_valid,
  input  logic [1:0]                  tx_dest,
  input  logic [LEN_W-1:0]            tx_len,
  output logic                        tx_ready,
  input  logic                        router_free,
  output logic [7:0]                  flit_out,
  output logic                        busy,
  output logic                        pkt_done,
  output logic                        err_illegal,
  output logic                        err_self
`ifdef NI_STATS_EN
  ,
  output logic [15:0]                 pkt_cnt,
  output logic [15:0]                 flit_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int GAP_W = $clog2(MIN_GAP + 1);

  tx_state_e        state_q, state_d;
  logic [7:0]       flit_d;
  logic             pkt_done_d, err_illegal_d, err_self_d;
  logic [1:0]       dest_q, dest_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             pop_req;
  logic             fifo_empty;
  logic [7:0]       fifo_data;
  logic [7:0]       body_flit;
  logic             body_bad;

  ni_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop_req && !fifo_empty),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign body_bad  = is_reserved(fifo_data);
  assign body_flit = body_bad ? FLIT_SUBST : fifo_data;
  assign busy      = (state_q != IDLE);
  assign tx_ready  = !rst && (state_q == IDLE) && (gap_q == '0) &&
                     (fifo_count >= CNT_W'(tx_len));

  // Next-state and next-output: the registered flit always matches the state being entered
  always_comb begin
    state_d       = state_q;
    flit_d        = FLIT_IDLE;
    pkt_done_d    = 1'b0;
    err_illegal_d = 1'b0;
    err_self_d    = 1'b0;
    dest_d        = dest_q;
    len_d         = len_q;
    rem_d         = rem_q;
    gap_d         = gap_q;
    pop_req       = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          if (tx_dest == current_node) begin
            err_self_d = 1'b1;
          end else begin
            dest_d  = tx_dest;
            len_d   = tx_len;
            state_d = WAIT_FREE;
          end
        end
      end
      WAIT_FREE: begin
        if (router_free) begin
          state_d = HEAD;
          flit_d  = {HEAD_TAG, dest_q};
        end
      end
      HEAD, BODY: begin
        if ((state_q == HEAD) ? (len_q != '0) : (rem_q != '0)) begin
          state_d       = BODY;
          pop_req       = 1'b1;
          flit_d        = body_flit;
          err_illegal_d = body_bad;
          rem_d         = ((state_q == HEAD) ? len_q : rem_q) - 1'b1;
        end else begin
          state_d    = TAIL;
          flit_d     = FLIT_TAIL;
          pkt_done_d = 1'b1;
        end
      end
      TAIL: begin
        state_d = GAP;
        gap_d   = GAP_W'(MIN_GAP);
      end
      GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q == GAP_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched command and registered line outputs; reset drops the line to idle at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flit_out    <= FLIT_IDLE;
      pkt_done    <= 1'b0;
      err_illegal <= 1'b0;
      err_self    <= 1'b0;
      dest_q      <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      flit_out    <= flit_d;
      pkt_done    <= pkt_done_d;
      err_illegal <= err_illegal_d;
      err_self    <= err_self_d;
      dest_q      <= dest_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      gap_q       <= gap_d;
    end
  end

`ifdef NI_STATS_EN
  // Traffic counters: one packet per tail, one flit per head/body/tail cycle, free-running wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt  <= '0;
      flit_cnt <= '0;
    end else begin
      if (pkt_done_d) pkt_cnt <= pkt_cnt + 1'b1;
      if (state_d == HEAD || state_d == BODY || state_d == TAIL) flit_cnt <= flit_cnt + 1'b1;
    end
  end
`endif

endmodule
